mu0_control_unit: RTL
=====================

# mu0_control_unit

Parametrised MU0 control unit: the instruction-cycle sequencer and the opcode decoder merged into one block. It owns the FETCH/EXEC1/EXEC2 state machine, which was previously external, and adds a multi-cycle barrel-free shift sequence for LSL/LSR with an IR-encoded shift amount. It sits between the IR/ACC registers and the datapath muxes, PC counter and memory write-enable, and drives every datapath control line each cycle.

## Interface
- DATA_W, 16, word width; the opcode is always IR[DATA_W-1:DATA_W-4].
- SHAMT_W, 4, width of the shift-amount field IR[SHAMT_W-1:0]; must be ≤ DATA_W-4.
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- RUN  in  1  high lets the sequencer leave IDLE and continue fetching.
- IR  in  DATA_W  instruction register contents, valid from EXEC1 onwards.
- ACC_OUT  in  DATA_W  accumulator value, used for EQ/MI.
- FETCH, EXEC1, EXEC2, SHIFTING  out  1 each  registered one-hot state indicators.
- HALTED  out  1  high in HALT.
- ILLEGAL  out  1  one-cycle pulse in EXEC1 for opcodes B–F.
- IR_LOAD  out  1  IR captures memory data at the end of this cycle.
- MUX1  out  1  1 = memory address from the IR address field; 0 = from PC.
- MUX3  out  1  1 = ACC source from memory/ALU path; 0 = from shifter/immediate.
- SLOAD  out  1  load PC from the IR address field.
- CNT_EN  out  1  increment PC.
- WREN  out  1  memory write.
- SLOAD_ACC, ENABLE_ACC  out  1 each  accumulator load and enable.
- ADD_SUB  out  1  1 = add, 0 = subtract.
- SHIFT  out  1  shift ACC by one bit this cycle.
- MUX4  out  1  shift direction: 1 = right (LSR), 0 = left.
- FORCINGZERO  out  1  zero-extend the IR field into the ACC (LDI).

## Operation
- States: IDLE, FETCH, EXEC1, EXEC2, SHIFT, HALT.
- IDLE:
  - Goes to FETCH when RUN=1.
  - All outputs are 0.
- FETCH:
  - Asserts IR_LOAD with MUX1=0.
  - Always goes to EXEC1.
- EXEC1 decode (EQ = ACC_OUT==0, MI = ACC_OUT[DATA_W-1]):
  - LDA/ADD/SUB (0/2/3): MUX1=1, MUX3=1, then EXEC2.
  - STA (1): MUX1=1, WREN=1, CNT_EN=1.
  - JMP (4), JMI (5) when MI, JEQ (6) when EQ: MUX1=1, SLOAD=1, CNT_EN=0. A conditional jump whose condition fails gives CNT_EN=1 only.
  - STP (7): no PC change, go to HALT.
  - LDI (8): FORCINGZERO=1, SLOAD_ACC=1, ENABLE_ACC=1, CNT_EN=1.
  - LSL/LSR (9/A): load the down-counter with IR[SHAMT_W-1:0]. If the count is 0, assert CNT_EN and go to FETCH; otherwise go to SHIFT.
  - B–F: ILLEGAL=1, CNT_EN=1 (treated as NOP).
- EXEC2 (LDA/ADD/SUB): MUX1=1, MUX3=1, SLOAD_ACC=1, ENABLE_ACC=1, CNT_EN=1. ADD_SUB=1 for ADD, 0 otherwise.
- SHIFT:
  - Each cycle asserts SHIFT=1 and ENABLE_ACC=1, with MUX4=1 for LSR, then decrements the counter.
  - The cycle with count==1 also asserts CNT_EN and returns to the next state.
- Next state after an instruction completes: FETCH if RUN=1, IDLE if RUN=0.
- RUN=0 never aborts an instruction in progress; it is sampled only at instruction end.
- HALT: held until reset; RUN is ignored.
- Reset:
  - Asynchronous entry to IDLE from any state, including mid-SHIFT and mid-EXEC2.
  - Counter is cleared to 0; every output is 0.

## Timing
- Decode outputs are combinational from the registered state, IR and ACC_OUT; state indicators are registered.
- Cycles per instruction:
  - STA, JMP/JMI/JEQ, LDI, NOP, and shift with shamt 0: 2 (FETCH, EXEC1).
  - LDA/ADD/SUB: 3.
  - LSL/LSR: 2+shamt, maximum 2+(2^SHAMT_W-1).
  - STP: 2, then HALT.
- EQ/MI are sampled in EXEC1 only and reflect the ACC value written by the previous instruction.
- SLOAD and CNT_EN are never high in the same cycle.
- Exactly one CNT_EN or SLOAD pulse occurs per completed non-STP instruction.

## Configuration
- MU0_SHIFT_EN defined: LSL/LSR are implemented as described; the counter and SHIFT state exist.
- MU0_SHIFT_EN undefined:
  - Opcodes 9/A decode as NOP: CNT_EN in EXEC1, ILLEGAL=0.
  - The SHIFT state and counter are not built; SHIFT, MUX4 and SHIFTING are tied to 0.

## Test plan
- Reset with RUN=1 → IDLE with all outputs 0. Release reset → FETCH next cycle with IR_LOAD=1; IR=0x0005 (LDA) → EXEC1 (MUX1=1, MUX3=1), then EXEC2 (SLOAD_ACC=1, CNT_EN=1), then FETCH.
- IR=0x5020 (JMI): with ACC_OUT=0x8000 → SLOAD=1, CNT_EN=0; with ACC_OUT=0x7FFF → SLOAD=0, CNT_EN=1.
- IR=0x9003 (LSL by 3) → three SHIFTING cycles with SHIFT=1, MUX4=0; CNT_EN only on the third. IR=0xA000 → CNT_EN in EXEC1, no SHIFT cycles.
- Assert RESET_N=0 during the second SHIFT cycle of IR=0xA00F → immediately IDLE, counter 0, all outputs 0.
- IR=0x7000 (STP) → HALTED=1 and stays there with RUN toggling; IR=0xB123 → ILLEGAL pulse, CNT_EN=1.
- Drop RUN during EXEC1 of ADD (0x2010) → EXEC2 completes with CNT_EN=1, then IDLE.

Source files
------------

// File: rtl/mu0_control_unit.sv
// MU0 control unit: instruction-cycle sequencer plus opcode decoder driving every datapath control line.
// Define MU0_SHIFT_EN to build the multi-cycle LSL/LSR shift sequence; otherwise opcodes 9/A act as NOPs.
module mu0_control_unit #(
    parameter int DATA_W  = 16,
    parameter int SHAMT_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run_i,
    input  logic [DATA_W-1:0] ir_i,
    input  logic [DATA_W-1:0] acc_out_i,
    output logic              fetch_o,
    output logic              exec1_o,
    output logic              exec2_o,
    output logic              shifting_o,
    output logic              halted_o,
    output logic              illegal_o,
    output logic              ir_load_o,
    output logic              mux1_o,
    output logic              mux3_o,
    output logic              sload_o,
    output logic              cnt_en_o,
    output logic              wren_o,
    output logic              sload_acc_o,
    output logic              enable_acc_o,
    output logic              add_sub_o,
    output logic              shift_o,
    output logic              mux4_o,
    output logic              forcingzero_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC1,
        S_EXEC2,
        S_SHIFT,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JMI = 4'h5;
    localparam logic [3:0] OP_JEQ = 4'h6;
    localparam logic [3:0] OP_STP = 4'h7;
    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_LSL = 4'h9;
    localparam logic [3:0] OP_LSR = 4'hA;

    state_t     state_q, state_d;
    state_t     end_state;
    logic [3:0] opcode;
    logic       acc_eq;
    logic       acc_mi;
    logic       unused_ir;

    assign opcode    = ir_i[DATA_W-1:DATA_W-4];
    assign acc_eq    = (acc_out_i == '0);
    assign acc_mi    = acc_out_i[DATA_W-1];
    assign unused_ir = ^ir_i;
    // RUN only matters at instruction boundaries, never mid-instruction.
    assign end_state = run_i ? S_FETCH : S_IDLE;

`ifdef MU0_SHIFT_EN
    logic [SHAMT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign shifting_o = (state_q == S_SHIFT);
`else
    assign shifting_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign fetch_o  = (state_q == S_FETCH);
    assign exec1_o  = (state_q == S_EXEC1);
    assign exec2_o  = (state_q == S_EXEC2);
    assign halted_o = (state_q == S_HALT);

    always_comb begin
        state_d       = state_q;
        illegal_o     = 1'b0;
        ir_load_o     = 1'b0;
        mux1_o        = 1'b0;
        mux3_o        = 1'b0;
        sload_o       = 1'b0;
        cnt_en_o      = 1'b0;
        wren_o        = 1'b0;
        sload_acc_o   = 1'b0;
        enable_acc_o  = 1'b0;
        add_sub_o     = 1'b0;
        shift_o       = 1'b0;
        mux4_o        = 1'b0;
        forcingzero_o = 1'b0;
`ifdef MU0_SHIFT_EN
        cnt_d         = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (run_i) state_d = S_FETCH;
            end
            S_FETCH: begin
                ir_load_o = 1'b1;
                state_d   = S_EXEC1;
            end
            S_EXEC1: begin
                state_d = end_state;
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        mux1_o  = 1'b1;
                        mux3_o  = 1'b1;
                        state_d = S_EXEC2;
                    end
                    OP_STA: begin
                        mux1_o   = 1'b1;
                        wren_o   = 1'b1;
                        cnt_en_o = 1'b1;
                    end
                    OP_JMP, OP_JMI, OP_JEQ: begin
                        // A failed conditional jump just steps the PC.
                        if ((opcode == OP_JMP) || (opcode == OP_JMI && acc_mi) ||
                            (opcode == OP_JEQ && acc_eq)) begin
                            mux1_o  = 1'b1;
                            sload_o = 1'b1;
                        end else begin
                            cnt_en_o = 1'b1;
                        end
                    end
                    OP_STP: begin
                        state_d = S_HALT;
                    end
                    OP_LDI: begin
                        forcingzero_o = 1'b1;
                        sload_acc_o   = 1'b1;
                        enable_acc_o  = 1'b1;
                        cnt_en_o      = 1'b1;
                    end
`ifdef MU0_SHIFT_EN
                    OP_LSL, OP_LSR: begin
                        cnt_d = ir_i[SHAMT_W-1:0];
                        if (ir_i[SHAMT_W-1:0] == '0) begin
                            cnt_en_o = 1'b1;
                        end else begin
                            state_d = S_SHIFT;
                        end
                    end
`else
                    OP_LSL, OP_LSR: begin
                        cnt_en_o = 1'b1;
                    end
`endif
                    default: begin
                        illegal_o = 1'b1;
                        cnt_en_o  = 1'b1;
                    end
                endcase
            end
            S_EXEC2: begin
                mux1_o       = 1'b1;
                mux3_o       = 1'b1;
                sload_acc_o  = 1'b1;
                enable_acc_o = 1'b1;
                cnt_en_o     = 1'b1;
                add_sub_o    = (opcode == OP_ADD);
                state_d      = end_state;
            end
`ifdef MU0_SHIFT_EN
            S_SHIFT: begin
                shift_o      = 1'b1;
                enable_acc_o = 1'b1;
                mux4_o       = (opcode == OP_LSR);
                cnt_d        = cnt_q - 1'b1;
                if (cnt_q == SHAMT_W'(1)) begin
                    cnt_en_o = 1'b1;
                    state_d  = end_state;
                end
            end
`endif
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
